axi_rand_rd_resp: RTL and testbench

AXI-Lite read-response stage of the random-number peripheral. It consumes the per-transfer address-accept pulse (`ar_cs`) and captured address from the read-address channel handshake. It then drives the R channel (`rvalid`/`rdata`/`rresp`) and holds each response until `rready`. It owns the 32-bit Galois LFSR, a last-value register, a read counter and a sticky overrun flag.

---
 rtl/axi_rand_rd_resp_if.sv | 24 ++
 rtl/axi_rand_rd_resp.sv | 166 ++++++++++++++++
 tb/tb_axi_rand_rd_resp.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rand_rd_resp_if.sv
// Read-address/read-response bundle for the random-number peripheral.
// The master side (interconnect) presents accepted read addresses and the
// R channel ready; the slave side (axi_rand_rd_resp) returns the response.
interface axi_rand_rd_resp_if #(
  parameter int ADDR_W = 5
);
  logic              ar_cs;
  logic [ADDR_W-1:0] araddr;
  logic              busy;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output ar_cs, araddr, rready,
    input  busy, rvalid, rdata, rresp
  );

  modport slave (
    input  ar_cs, araddr, rready,
    output busy, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_rand_rd_resp.sv
// AXI-Lite read-response stage of the random-number peripheral.
// Owns the 32-bit Galois LFSR, the last-value register, the read counter
// and the sticky overrun flag. Register map (word-aligned):
//   0x00 random value (steps LFSR), 0x04 last random value,
//   0x08 read count, 0x0C overrun flag (read-to-clear), others SLVERR.
// Optional feature macro: RAND_SEED_LOAD_EN adds seed_we/seed_data so
// software can reseed the LFSR at runtime.
module axi_rand_rd_resp #(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] SEED      = 32'hACE12468,
  parameter logic [31:0] LFSR_MASK = 32'h80200003
) (
  input  logic                     clk,
  input  logic                     anreset,
`ifdef RAND_SEED_LOAD_EN
  input  logic                     seed_we,
  input  logic [31:0]              seed_data,
`endif
  axi_rand_rd_resp_if.slave        bus
);

  localparam int WORD_W = ADDR_W - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t              state_q;
  logic                rvalid_q;
  logic                busy_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic [31:0]         lfsr_q;
  logic [31:0]         last_q;
  logic [31:0]         count_q;
  logic                overrun_q;

  logic [WORD_W-1:0]   wordIdx;
  logic [31:0]         lfsrStep;
  logic                acceptRead;
  logic                dropRead;
  logic                readRand;
  logic                readStatus;
  logic [31:0]         rdata_d;
  logic [1:0]          rresp_d;
  logic [31:0]         lfsr_d;
  logic                overrun_d;
  logic [1:0]          unusedAddrBits;

  // Byte-lane bits of the address carry no meaning for a word-only map.
  assign unusedAddrBits = bus.araddr[1:0];

  // Address decode and response selection for a read captured this edge.
  always_comb begin
    wordIdx    = bus.araddr[ADDR_W-1:2];
    lfsrStep   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    acceptRead = (state_q == IDLE) && bus.ar_cs;
    dropRead   = (state_q == RESP) && bus.ar_cs;
    readRand   = 1'b0;
    readStatus = 1'b0;
    rdata_d    = '0;
    rresp_d    = RESP_OKAY;
    case (wordIdx)
      WORD_W'(0): begin
        rdata_d  = lfsr_q;
        readRand = acceptRead;
      end
      WORD_W'(1): rdata_d = last_q;
      WORD_W'(2): rdata_d = count_q;
      WORD_W'(3): begin
        rdata_d    = {31'b0, overrun_q};
        readStatus = acceptRead;
      end
      default: begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    endcase
  end

  // Next LFSR value: a 0x00 read steps it, a seed load takes priority.
  always_comb begin
    lfsr_d = lfsr_q;
    if (readRand) begin
      lfsr_d = lfsrStep;
    end
`ifdef RAND_SEED_LOAD_EN
    if (seed_we) begin
      lfsr_d = (seed_data == 32'h0) ? SEED : seed_data;
    end
`endif
  end

  // Sticky overrun: a dropped pulse sets it and beats a same-edge clear.
  always_comb begin
    overrun_d = overrun_q;
    if (readStatus) begin
      overrun_d = 1'b0;
    end
    if (dropRead) begin
      overrun_d = 1'b1;
    end
  end

  // Response FSM with registered R-channel outputs and side-effect state.
  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      lfsr_q    <= SEED;
      last_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (bus.ar_cs) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            count_q  <= count_q + 32'd1;
            if (readRand) begin
              last_q <= lfsr_q;
            end
          end
        end
        RESP: begin
          if (bus.rready) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // A zero LFSR would lock up forever; zero SEED is the only way in.
  always_ff @(posedge clk) begin
    if (anreset) begin
      assert (lfsr_q != 32'h0);
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

endmodule

// File: tb/tb_axi_rand_rd_resp.sv
// Directed testbench for axi_rand_rd_resp with a response scoreboard.
// Expected responses come from a small behavioural model of the register
// map and are queued when a read is issued, then popped when it returns.
module tb_axi_rand_rd_resp;

  localparam int          ADDR_W = 5;
  localparam logic [31:0] SEED   = 32'hACE12468;
  localparam logic [31:0] MASK   = 32'h80200003;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic clk = 1'b0;
  logic anreset;

  always #5 clk = ~clk;

  axi_rand_rd_resp_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef RAND_SEED_LOAD_EN
  logic        seed_we;
  logic [31:0] seed_data;
`endif

  axi_rand_rd_resp #(
    .ADDR_W   (ADDR_W),
    .SEED     (SEED),
    .LFSR_MASK(MASK)
  ) dut (
    .clk      (clk),
    .anreset  (anreset),
`ifdef RAND_SEED_LOAD_EN
    .seed_we  (seed_we),
    .seed_data(seed_data),
`endif
    .bus      (bus)
  );

  exp_t        scoreboard[$];
  logic [31:0] mLfsr;
  logic [31:0] mLast;
  logic [31:0] mCount;
  logic        mOverrun;
  int          passCount = 0;
  int          failCount = 0;
  int          checkCount = 0;

  function automatic logic [31:0] lfsrNext(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ MASK) : (v >> 1);
  endfunction

  task automatic modelReset();
    mLfsr    = SEED;
    mLast    = 32'h0;
    mCount   = 32'h0;
    mOverrun = 1'b0;
    scoreboard.delete();
  endtask

  task automatic predictRead(input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.data = 32'h0;
    e.resp = 2'b00;
    case (addr[ADDR_W-1:2])
      3'd0: begin
        e.data = mLfsr;
        mLast  = mLfsr;
        mLfsr  = lfsrNext(mLfsr);
      end
      3'd1: e.data = mLast;
      3'd2: e.data = mCount;
      3'd3: begin
        e.data   = {31'b0, mOverrun};
        mOverrun = 1'b0;
      end
      default: begin
        e.data = 32'h0;
        e.resp = 2'b10;
      end
    endcase
    mCount = mCount + 32'd1;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one read from IDLE; returns at the negedge after the capture edge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic rdy);
    @(negedge clk);
    checkOutput("pre_rvalid", 32'(bus.rvalid), 32'h0);
    predictRead(addr);
    bus.ar_cs  = 1'b1;
    bus.araddr = addr;
    bus.rready = rdy;
    @(negedge clk);
    bus.ar_cs  = 1'b0;
  endtask

  task automatic checkResponse(input string tag, output exp_t e);
    e = '0;
    if (scoreboard.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, "_rvalid"}, 32'(bus.rvalid), 32'h1);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h1);
      checkOutput({tag, "_rdata"}, bus.rdata, e.data);
      checkOutput({tag, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
    end
  endtask

  task automatic finishRead(input string tag);
    bus.rready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_done_rvalid"}, 32'(bus.rvalid), 32'h0);
    checkOutput({tag, "_done_busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic simpleRead(input logic [ADDR_W-1:0] addr, input string tag,
                            output exp_t e);
    applyStimulus(addr, 1'b1);
    checkResponse(tag, e);
    finishRead(tag);
  endtask

  initial begin
    exp_t e;
    anreset    = 1'b0;
    bus.ar_cs  = 1'b0;
    bus.araddr = '0;
    bus.rready = 1'b1;
`ifdef RAND_SEED_LOAD_EN
    seed_we   = 1'b0;
    seed_data = 32'h0;
`endif
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_rresp", 32'(bus.rresp), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    anreset = 1'b1;

    // Two random reads, last value, counter
    simpleRead(5'h00, "rand1", e);
    checkOutput("rand1_const", e.data, 32'hACE12468);
    simpleRead(5'h00, "rand2", e);
    checkOutput("rand2_const", e.data, 32'h56709234);
    simpleRead(5'h04, "last1", e);
    checkOutput("last1_const", e.data, 32'h56709234);
    simpleRead(5'h08, "count1", e);
    checkOutput("count1_const", e.data, 32'h3);
    simpleRead(5'h08, "count2", e);
    checkOutput("count2_const", e.data, 32'h4);

    // Back-pressure: response held stable while rready is low
    applyStimulus(5'h00, 1'b0);
    checkResponse("hold", e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hold_rvalid", 32'(bus.rvalid), 32'h1);
      checkOutput("hold_busy", 32'(bus.busy), 32'h1);
      checkOutput("hold_rdata", bus.rdata, e.data);
    end
    finishRead("hold");

    // Unmapped address: SLVERR, last untouched
    simpleRead(5'h14, "slverr", e);
    checkOutput("slverr_resp", 32'(e.resp), 32'h2);
    simpleRead(5'h04, "last2", e);

    // Overrun: pulse during RESP is dropped
    applyStimulus(5'h00, 1'b0);
    checkResponse("ovr", e);
    @(negedge clk);
    bus.ar_cs  = 1'b1;
    bus.araddr = 5'h08;
    mOverrun   = 1'b1;
    @(negedge clk);
    bus.ar_cs  = 1'b0;
    checkOutput("ovr_rvalid", 32'(bus.rvalid), 32'h1);
    checkOutput("ovr_rdata", bus.rdata, e.data);
    finishRead("ovr");
    simpleRead(5'h08, "ovr_count", e);
    simpleRead(5'h0C, "ovr_flag1", e);
    checkOutput("ovr_flag1_const", e.data, 32'h1);
    simpleRead(5'h0C, "ovr_flag2", e);
    checkOutput("ovr_flag2_const", e.data, 32'h0);

    // Pulse on the handshake edge is still dropped
    applyStimulus(5'h04, 1'b1);
    checkResponse("hsdrop", e);
    bus.ar_cs  = 1'b1;
    bus.araddr = 5'h00;
    mOverrun   = 1'b1;
    @(negedge clk);
    bus.ar_cs  = 1'b0;
    checkOutput("hsdrop_rvalid", 32'(bus.rvalid), 32'h0);
    simpleRead(5'h00, "hsdrop_rand", e);
    simpleRead(5'h0C, "hsdrop_flag", e);
    checkOutput("hsdrop_flag_const", e.data, 32'h1);

    // Asynchronous reset in the middle of a response
    applyStimulus(5'h00, 1'b0);
    checkResponse("arst", e);
    #2 anreset = 1'b0;
    #1;
    checkOutput("arst_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("arst_busy", 32'(bus.busy), 32'h0);
    checkOutput("arst_rdata", bus.rdata, 32'h0);
    modelReset();
    @(negedge clk);
    anreset = 1'b1;
    simpleRead(5'h00, "arst_rand", e);
    checkOutput("arst_rand_const", e.data, 32'hACE12468);

`ifdef RAND_SEED_LOAD_EN
    // Runtime reseed, including the zero-means-SEED case
    @(negedge clk);
    seed_we   = 1'b1;
    seed_data = 32'h12345678;
    @(negedge clk);
    seed_we   = 1'b0;
    mLfsr     = 32'h12345678;
    simpleRead(5'h00, "seed1", e);
    checkOutput("seed1_const", e.data, 32'h12345678);
    @(negedge clk);
    seed_we   = 1'b1;
    seed_data = 32'h0;
    @(negedge clk);
    seed_we   = 1'b0;
    mLfsr     = SEED;
    simpleRead(5'h00, "seed0", e);
    checkOutput("seed0_const", e.data, SEED);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
